// File: rtl/rp_8bit_io_bank.sv
// rtl/rp_8bit_io_bank.sv - I/O register bank with interrupt flag/mask registers
//
// Purpose:
//   2**AW registers of DW bits, written under a per-bit mask and read back
//   with one cycle of latency. Two addresses are special:
//     IFA : interrupt flag register (IFR). Bits are set by evt and cleared
//           by write-one-to-clear or by irq_ack. Set beats clear.
//     IMA : interrupt mask register (IMR). Written like a general register.
//   irq_req = IFR & IMR. It is built from registered state only.
//   Bits [DW-1:IRW] of IFR and IMR read as 0. IRW must not exceed DW.
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous active-high reset
//   io_wen   in   1    write enable
//   io_ren   in   1    read enable
//   io_adr   in   AW   register address (fully decoded)
//   io_wdt   in   DW   write data
//   io_msk   in   DW   write bit mask, 1 = bit written
//   io_rdt   out  DW   registered read data
//   evt      in   IRW  event pulses, one per interrupt channel
//   irq_req  out  IRW  interrupt requests
//   irq_ack  in   IRW  interrupt acknowledges
module rp_8bit_io_bank #(
  parameter int             AW  = 6,
  parameter int             DW  = 8,
  parameter int             IRW = 8,
  parameter logic [AW-1:0]  IFA = 6'h3a,
  parameter logic [AW-1:0]  IMA = 6'h3b
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           io_wen,
  input  logic           io_ren,
  input  logic [AW-1:0]  io_adr,
  input  logic [DW-1:0]  io_wdt,
  input  logic [DW-1:0]  io_msk,
  output logic [DW-1:0]  io_rdt,
  input  logic [IRW-1:0] evt,
  output logic [IRW-1:0] irq_req,
  input  logic [IRW-1:0] irq_ack
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0]  r_mem [NREG];
  logic [IRW-1:0] r_ifr;
  logic [IRW-1:0] r_imr;
  logic [DW-1:0]  r_rdt;

  logic           w_sel_ifr;
  logic           w_sel_imr;
  logic           w_wr_gen;
  logic [DW-1:0]  w_gen_merge;
  logic [IRW-1:0] w_imr_merge;
  logic [IRW-1:0] w_w1c;
  logic [IRW-1:0] w_ifr_nxt;
  logic [DW-1:0]  w_rd_val;

  assign w_sel_ifr = (io_adr == IFA);
  assign w_sel_imr = (io_adr == IMA);
  assign w_wr_gen  = io_wen && !w_sel_ifr && !w_sel_imr;

  assign w_gen_merge = (io_wdt & io_msk) | (r_mem[io_adr] & ~io_msk);
  assign w_imr_merge = (io_wdt[IRW-1:0] & io_msk[IRW-1:0]) | (r_imr & ~io_msk[IRW-1:0]);

  // Only bits written as 1 clear a flag; a 0 in io_wdt leaves the flag alone.
  assign w_w1c = (io_wen && w_sel_ifr) ? (io_wdt[IRW-1:0] & io_msk[IRW-1:0]) : '0;

  // OR-ing evt last makes a same-edge set win over any clear source.
  assign w_ifr_nxt = (r_ifr & ~(w_w1c | irq_ack)) | evt;

  // Read mux over pre-edge state; the upper IFR/IMR bits stay zero.
  always_comb begin
    w_rd_val = '0;
    if (w_sel_ifr) begin
      w_rd_val[IRW-1:0] = r_ifr;
    end else if (w_sel_imr) begin
      w_rd_val[IRW-1:0] = r_imr;
    end else begin
      w_rd_val = r_mem[io_adr];
    end
  end

  // General register file. Entries at IFA/IMA are never written or read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_gen) begin
      r_mem[io_adr] <= w_gen_merge;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imr <= '0;
    end else if (io_wen && w_sel_imr) begin
      r_imr <= w_imr_merge;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifr <= '0;
    end else begin
      r_ifr <= w_ifr_nxt;
    end
  end

  // Read data captures the pre-edge value, so a same-cycle write to the
  // same address returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdt <= '0;
    end else if (io_ren) begin
      r_rdt <= w_rd_val;
    end
  end

  assign io_rdt  = r_rdt;
  assign irq_req = r_ifr & r_imr;

endmodule

// File: doc/rp_8bit_io_bank.md
RP_8BIT_IO_BANK -- requirements
Module: rp_8bit_io_bank

Interface
REQ-001 Parameter AW, default 6: I/O address width; register count 2**AW.
REQ-002 Parameter DW, default 8: register and I/O data width.
REQ-003 Parameter IRW, default 8: interrupt channel count; IRW <= DW.
REQ-004 Parameter IFA, default 6'h3a: address of interrupt flag register (IFR).
REQ-005 Parameter IMA, default 6'h3b: address of interrupt mask register (IMR); IMA != IFA.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 io_wen  input  1  write enable.
REQ-009 io_ren  input  1  read enable.
REQ-010 io_adr  input  AW  register address.
REQ-011 io_wdt  input  DW  write data.
REQ-012 io_msk  input  DW  write bit mask; 1 = bit written.
REQ-013 io_rdt  output  DW  registered read data.
REQ-014 evt  input  IRW  peripheral event pulses, one bit per channel.
REQ-015 irq_req  output  IRW  interrupt request to core.
REQ-016 irq_ack  input  IRW  interrupt acknowledge from core.

Function
REQ-017 General registers (all addresses except IFA, IMA): on io_wen, reg[io_adr] <= io_wdt & io_msk | reg[io_adr] & ~io_msk, in the same clock edge.
REQ-018 io_msk = 0 with io_wen = 1 leaves the addressed register unchanged.
REQ-019 io_rdt updates only on an edge with io_ren = 1, to the pre-edge value of reg[io_adr]; 1-cycle read latency; holds its value otherwise.
REQ-020 Read and write to the same address in one cycle: io_rdt returns the old value; the write takes effect.
REQ-021 IMR: written like a general register; bits [DW-1:IRW] always read 0 and ignore writes.
REQ-022 IFR bit n set on an edge where evt[n] = 1.
REQ-023 IFR bit n cleared on an edge where io_wen = 1, io_adr = IFA, io_msk[n] = 1, io_wdt[n] = 1 (write-one-to-clear); io_wdt[n] = 0 has no effect.
REQ-024 IFR bit n cleared on an edge where irq_ack[n] = 1; multiple ack bits clear multiple flags.
REQ-025 Simultaneous set (evt) and clear (W1C or ack) on the same bit: set wins, flag stays/becomes 1.
REQ-026 IFR bits [DW-1:IRW] always read 0.
REQ-027 irq_req = IFR[IRW-1:0] & IMR[IRW-1:0], combinational from registered state only (no path from evt or io_* to irq_req).
REQ-028 irq_req rises the cycle after the edge that sets the flag with mask already 1, or that sets the mask with flag already 1.
REQ-029 Address decode uses all AW bits; no aliasing.

Reset
REQ-030 While rst = 1: all 2**AW registers, IFR, IMR, io_rdt = 0; irq_req = 0.
REQ-031 Reset asserted mid-write or mid-read discards the transaction; no partial update after rst deassertion.
REQ-032 First write/read honoured on the first rising edge with rst = 0.

Verification
REQ-033 Reset, then write adr 5 wdt 8'hA5 msk 8'hFF; read adr 5 -> io_rdt = 8'hA5 one cycle after io_ren.
REQ-034 reg[5] = 8'hA5, write wdt 8'h0F msk 8'h0C -> reg[5] = 8'hAD; msk 8'h00 write -> unchanged.
REQ-035 Same-cycle read+write adr 7 (old 8'h11, new 8'h22) -> io_rdt = 8'h11; next read -> 8'h22.
REQ-036 IMR = 8'h04, evt = 8'h04 one cycle -> IFR = 8'h04, irq_req = 8'h04 next cycle; irq_ack = 8'h04 -> irq_req = 0 next cycle.
REQ-037 IFR = 8'h06; W1C write wdt 8'h02 msk 8'hFF concurrent with evt = 8'h02 -> IFR = 8'h06 (set wins); then W1C 8'h06 -> IFR = 0.
REQ-038 Write 8'hFF to all 64 addresses, assert rst asynchronously mid-cycle -> all reads return 0, irq_req = 0 immediately.
